arm_wb_unit: RTL and testbench

//  Parametrised write-back stage: MEM/WB pipeline register, load-data alignment and extension,
//  and register-file write sequencing for instructions with two destinations (load/store with

---
 rtl/arm_wb_unit_if.sv | 40 ++++
 rtl/arm_wb_unit.sv | 122 ++++++++++++
 tb/tb_arm_wb_unit.sv | 315 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/arm_wb_unit_if.sv
// MEM->WB entry handshake plus the register-file write ports and retire count.
interface arm_wb_unit_if #(
  parameter int REG_ADDR_W = 4
);
  logic                  flush;
  logic                  in_valid;
  logic                  in_ready;
  logic [31:0]           in_mem_data;
  logic [31:0]           in_alu_data;
  logic                  in_rd_data_sel;
  logic                  in_rd_we;
  logic [REG_ADDR_W-1:0] in_rd_num;
  logic [1:0]            in_ld_size;
  logic                  in_ld_signed;
  logic [1:0]            in_addr_lo;
  logic                  in_base_we;
  logic [REG_ADDR_W-1:0] in_base_num;
  logic [31:0]           in_base_data;
  logic                  wb0_we;
  logic [REG_ADDR_W-1:0] wb0_num;
  logic [31:0]           wb0_data;
  logic                  wb1_we;
  logic [REG_ADDR_W-1:0] wb1_num;
  logic [31:0]           wb1_data;
  logic [31:0]           retired_cnt;

  // WB unit side
  modport slave (
    input  flush, in_valid, in_mem_data, in_alu_data, in_rd_data_sel, in_rd_we, in_rd_num,
           in_ld_size, in_ld_signed, in_addr_lo, in_base_we, in_base_num, in_base_data,
    output in_ready, wb0_we, wb0_num, wb0_data, wb1_we, wb1_num, wb1_data, retired_cnt
  );

  // MEM stage / register file side
  modport master (
    output flush, in_valid, in_mem_data, in_alu_data, in_rd_data_sel, in_rd_we, in_rd_num,
           in_ld_size, in_ld_signed, in_addr_lo, in_base_we, in_base_num, in_base_data,
    input  in_ready, wb0_we, wb0_num, wb0_data, wb1_we, wb1_num, wb1_data, retired_cnt
  );
endinterface

// File: rtl/arm_wb_unit.sv
// Write-back stage: MEM/WB register, load alignment/extension and RF write
// sequencing. With one write port a dual-destination entry takes two cycles
// (Rd, then base) and holds off MEM through in_ready.
module arm_wb_unit #(
  parameter int NUM_WR_PORTS     = 1,
  parameter int REG_ADDR_W       = 4,
  parameter bit ROTATE_UNALIGNED = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  arm_wb_unit_if.slave  bus
);

  localparam bit SINGLE = (NUM_WR_PORTS == 1);

  typedef enum logic [1:0] {IDLE, WR1, WR2} state_t;

  state_t                state_q;
  logic                  dual_q;
  logic [REG_ADDR_W-1:0] base_num_q;
  logic [31:0]           base_data_q;
  logic                  wb0_we_q, wb1_we_q;
  logic [REG_ADDR_W-1:0] wb0_num_q, wb1_num_q;
  logic [31:0]           wb0_data_q, wb1_data_q;
  logic [31:0]           cnt_q;

  logic [4:0]  sh;
  logic [31:0] rot_w;
  logic [7:0]  ld_b;
  logic [15:0] ld_h;
  logic [31:0] ld_data;
  logic [31:0] rd_val;
  logic        both_we, same_reg, dual_in, cap, last_cyc;

  assign sh    = {bus.in_addr_lo, 3'b000};
  assign rot_w = (bus.in_mem_data >> sh) | (bus.in_mem_data << (6'd32 - {1'b0, sh}));
  assign ld_b  = bus.in_mem_data[sh +: 8];
  assign ld_h  = bus.in_mem_data[{bus.in_addr_lo[1], 4'b0000} +: 16];

  // Load data alignment and extension; size 11 behaves as a word
  always_comb begin
    ld_data = bus.in_mem_data;
    case (bus.in_ld_size)
      2'b01:   ld_data = bus.in_ld_signed ? {{24{ld_b[7]}}, ld_b} : {24'h0, ld_b};
      2'b10:   ld_data = bus.in_ld_signed ? {{16{ld_h[15]}}, ld_h} : {16'h0, ld_h};
      default: ld_data = ROTATE_UNALIGNED ? rot_w : bus.in_mem_data;
    endcase
  end

  assign rd_val   = bus.in_rd_data_sel ? bus.in_alu_data : ld_data;
  assign both_we  = bus.in_rd_we && bus.in_base_we;
  // Rd==base: the loaded/ALU value wins and the base write is dropped
  assign same_reg = both_we && (bus.in_rd_num == bus.in_base_num);
  assign dual_in  = SINGLE && both_we && !same_reg;

  assign bus.in_ready = !(state_q == WR1 && dual_q);
  assign cap          = bus.in_valid && bus.in_ready && !bus.flush;
  assign last_cyc     = (state_q == WR1 && !dual_q) || (state_q == WR2);

  // Entry sequencing; write ports are registered so num/data hold when we drops
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      dual_q      <= 1'b0;
      base_num_q  <= '0;
      base_data_q <= '0;
      wb0_we_q    <= 1'b0;
      wb0_num_q   <= '0;
      wb0_data_q  <= '0;
      wb1_we_q    <= 1'b0;
      wb1_num_q   <= '0;
      wb1_data_q  <= '0;
      cnt_q       <= '0;
    end else begin
      if (last_cyc) cnt_q <= cnt_q + 32'd1;
      if (state_q == WR1 && dual_q) begin
        // second cycle of a serialised entry: base writeback
        state_q    <= WR2;
        dual_q     <= 1'b0;
        wb0_we_q   <= 1'b1;
        wb0_num_q  <= base_num_q;
        wb0_data_q <= base_data_q;
        wb1_we_q   <= 1'b0;
      end else if (cap) begin
        state_q     <= WR1;
        dual_q      <= dual_in;
        base_num_q  <= bus.in_base_num;
        base_data_q <= bus.in_base_data;
        wb0_we_q    <= bus.in_rd_we || bus.in_base_we;
        if (bus.in_rd_we) begin
          wb0_num_q  <= bus.in_rd_num;
          wb0_data_q <= rd_val;
        end else if (bus.in_base_we) begin
          wb0_num_q  <= bus.in_base_num;
          wb0_data_q <= bus.in_base_data;
        end
        if (!SINGLE) begin
          wb1_we_q <= both_we && !same_reg;
          if (both_we && !same_reg) begin
            wb1_num_q  <= bus.in_base_num;
            wb1_data_q <= bus.in_base_data;
          end
        end else begin
          wb1_we_q <= 1'b0;
        end
      end else begin
        state_q  <= IDLE;
        wb0_we_q <= 1'b0;
        wb1_we_q <= 1'b0;
      end
    end
  end

  assign bus.wb0_we      = wb0_we_q;
  assign bus.wb0_num     = wb0_num_q;
  assign bus.wb0_data    = wb0_data_q;
  assign bus.wb1_we      = wb1_we_q;
  assign bus.wb1_num     = wb1_num_q;
  assign bus.wb1_data    = wb1_data_q;
  assign bus.retired_cnt = cnt_q;

endmodule

// File: tb/tb_arm_wb_unit.sv
// Bench for arm_wb_unit: one single-port and one dual-port instance, a
// write-port scoreboard per port and directed handshake/flush/reset steps.
module tb_arm_wb_unit;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] mem, alu, bdata;
    logic        sel, rd_we, sgn, base_we;
    logic [1:0]  size, alo;
    logic [3:0]  rd, base;
  } req_t;

  typedef struct {
    logic [3:0]  num;
    logic [31:0] data;
  } wr_t;

  req_t        cur;
  logic        v1, v2, f1, f2;
  wr_t         q10[$], q20[$], q21[$];
  int          total = 0;
  int          bad = 0;
  logic [31:0] exp_cnt1 = 32'd0;

  arm_wb_unit_if #(.REG_ADDR_W(4)) if1 ();
  arm_wb_unit_if #(.REG_ADDR_W(4)) if2 ();

  assign if1.flush = f1;              assign if2.flush = f2;
  assign if1.in_valid = v1;           assign if2.in_valid = v2;
  assign if1.in_mem_data = cur.mem;   assign if2.in_mem_data = cur.mem;
  assign if1.in_alu_data = cur.alu;   assign if2.in_alu_data = cur.alu;
  assign if1.in_rd_data_sel = cur.sel; assign if2.in_rd_data_sel = cur.sel;
  assign if1.in_rd_we = cur.rd_we;    assign if2.in_rd_we = cur.rd_we;
  assign if1.in_rd_num = cur.rd;      assign if2.in_rd_num = cur.rd;
  assign if1.in_ld_size = cur.size;   assign if2.in_ld_size = cur.size;
  assign if1.in_ld_signed = cur.sgn;  assign if2.in_ld_signed = cur.sgn;
  assign if1.in_addr_lo = cur.alo;    assign if2.in_addr_lo = cur.alo;
  assign if1.in_base_we = cur.base_we; assign if2.in_base_we = cur.base_we;
  assign if1.in_base_num = cur.base;  assign if2.in_base_num = cur.base;
  assign if1.in_base_data = cur.bdata; assign if2.in_base_data = cur.bdata;

  arm_wb_unit #(.NUM_WR_PORTS(1), .REG_ADDR_W(4), .ROTATE_UNALIGNED(1'b1)) dut1 (
    .clk(clk), .rst(rst), .bus(if1.slave));
  arm_wb_unit #(.NUM_WR_PORTS(2), .REG_ADDR_W(4), .ROTATE_UNALIGNED(1'b1)) dut2 (
    .clk(clk), .rst(rst), .bus(if2.slave));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] align_model(input req_t r);
    logic [7:0]  b;
    logic [15:0] h;
    case (r.alo)
      2'd0:    b = r.mem[7:0];
      2'd1:    b = r.mem[15:8];
      2'd2:    b = r.mem[23:16];
      default: b = r.mem[31:24];
    endcase
    h = r.alo[1] ? r.mem[31:16] : r.mem[15:0];
    case (r.size)
      2'b01: return r.sgn ? {{24{b[7]}}, b} : {24'h0, b};
      2'b10: return r.sgn ? {{16{h[15]}}, h} : {16'h0, h};
      default: begin
        case (r.alo)
          2'd0:    return r.mem;
          2'd1:    return {r.mem[7:0], r.mem[31:8]};
          2'd2:    return {r.mem[15:0], r.mem[31:16]};
          default: return {r.mem[23:0], r.mem[31:24]};
        endcase
      end
    endcase
  endfunction

  function automatic req_t alu_op(input logic [3:0] rd, input logic [31:0] val);
    req_t r;
    r = '{mem: 32'h0, alu: val, bdata: 32'h0, sel: 1'b1, rd_we: 1'b1, sgn: 1'b0,
          base_we: 1'b0, size: 2'b00, alo: 2'b00, rd: rd, base: 4'h0};
    return r;
  endfunction

  function automatic req_t ld_op(input logic [3:0] rd, input logic [31:0] mem,
                                 input logic [1:0] size, input logic sgn, input logic [1:0] alo);
    req_t r;
    r = '{mem: mem, alu: 32'hDEAD_BEEF, bdata: 32'h0, sel: 1'b0, rd_we: 1'b1, sgn: sgn,
          base_we: 1'b0, size: size, alo: alo, rd: rd, base: 4'h0};
    return r;
  endfunction

  function automatic req_t with_base(input req_t r0, input logic [3:0] base, input logic [31:0] bd);
    req_t r;
    r = r0;
    r.base_we = 1'b1;
    r.base = base;
    r.bdata = bd;
    return r;
  endfunction

  // expected RF writes for one captured entry
  task automatic push_exp(input int which, input req_t r);
    logic [31:0] rv;
    rv = r.sel ? r.alu : align_model(r);
    if (which == 1) begin
      if (r.rd_we) q10.push_back('{r.rd, rv});
      if (r.base_we && !(r.rd_we && r.rd == r.base)) q10.push_back('{r.base, r.bdata});
      exp_cnt1 = exp_cnt1 + 32'd1;
    end else begin
      if (r.rd_we) q20.push_back('{r.rd, rv});
      if (r.base_we) begin
        if (!r.rd_we) q20.push_back('{r.base, r.bdata});
        else if (r.rd != r.base) q21.push_back('{r.base, r.bdata});
      end
    end
  endtask

  // offer at a negedge, wait out any stall, return at the negedge after capture
  task automatic send(input int which, input req_t r);
    int   n;
    logic rdy;
    cur = r;
    push_exp(which, r);
    if (which == 1) v1 = 1'b1; else v2 = 1'b1;
    n = 0;
    rdy = (which == 1) ? if1.in_ready : if2.in_ready;
    while (!rdy && n < 20) begin
      @(negedge clk);
      n++;
      rdy = (which == 1) ? if1.in_ready : if2.in_ready;
    end
    chk("ready_wait", {31'b0, rdy}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    v1 = 1'b0;
    v2 = 1'b0;
  endtask

  // scoreboard: every asserted write port must match the next expected write
  always @(negedge clk) begin
    wr_t e;
    if (!rst) begin
      if (if1.wb0_we) begin
        chk("d1_wb0_pending", {31'b0, q10.size() > 0}, 32'd1);
        if (q10.size() > 0) begin
          e = q10.pop_front();
          chk("d1_wb0_num", {28'b0, if1.wb0_num}, {28'b0, e.num});
          chk("d1_wb0_data", if1.wb0_data, e.data);
        end
      end
      chk("d1_wb1_we", {31'b0, if1.wb1_we}, 32'd0);
      if (if2.wb0_we) begin
        chk("d2_wb0_pending", {31'b0, q20.size() > 0}, 32'd1);
        if (q20.size() > 0) begin
          e = q20.pop_front();
          chk("d2_wb0_num", {28'b0, if2.wb0_num}, {28'b0, e.num});
          chk("d2_wb0_data", if2.wb0_data, e.data);
        end
      end
      if (if2.wb1_we) begin
        chk("d2_wb1_pending", {31'b0, q21.size() > 0}, 32'd1);
        if (q21.size() > 0) begin
          e = q21.pop_front();
          chk("d2_wb1_num", {28'b0, if2.wb1_num}, {28'b0, e.num});
          chk("d2_wb1_data", if2.wb1_data, e.data);
        end
      end
    end
  end

  initial begin
    req_t r;
    wr_t  dropped;
    rst = 1'b1; v1 = 1'b0; v2 = 1'b0; f1 = 1'b0; f2 = 1'b0;
    cur = alu_op(4'h0, 32'h0);
    cur.rd_we = 1'b0;
    repeat (2) @(negedge clk);
    // reset state
    chk("rst_ready", {31'b0, if1.in_ready}, 32'd1);
    chk("rst_we", {31'b0, if1.wb0_we}, 32'd0);
    chk("rst_num", {28'b0, if1.wb0_num}, 32'd0);
    chk("rst_data", if1.wb0_data, 32'd0);
    chk("rst_cnt", if1.retired_cnt, 32'd0);
    chk("rst_d2_wb1", {31'b0, if2.wb1_we}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // ALU result, one-cycle latency, then hold of num/data
    send(1, alu_op(4'd3, 32'h1234_5678));
    chk("alu_we", {31'b0, if1.wb0_we}, 32'd1);
    chk("alu_num", {28'b0, if1.wb0_num}, 32'd3);
    chk("alu_data", if1.wb0_data, 32'h1234_5678);
    @(negedge clk);
    chk("alu_we_off", {31'b0, if1.wb0_we}, 32'd0);
    chk("alu_num_hold", {28'b0, if1.wb0_num}, 32'd3);
    chk("alu_cnt", if1.retired_cnt, 32'd1);

    // loads, back to back
    send(1, ld_op(4'd1, 32'h00F0_8000, 2'b01, 1'b1, 2'd2));
    chk("ldrsb", if1.wb0_data, 32'hFFFF_FFF0);
    send(1, ld_op(4'd1, 32'h00F0_8000, 2'b01, 1'b0, 2'd2));
    chk("ldrb", if1.wb0_data, 32'h0000_00F0);
    send(1, ld_op(4'd2, 32'h8001_1234, 2'b10, 1'b1, 2'd2));
    chk("ldrsh", if1.wb0_data, 32'hFFFF_8001);
    send(1, ld_op(4'd3, 32'h8001_1234, 2'b00, 1'b0, 2'd1));
    chk("ldr_rot8", if1.wb0_data, 32'h3480_0112);
    send(1, ld_op(4'd4, 32'h8001_1234, 2'b10, 1'b0, 2'd3));
    send(1, ld_op(4'd5, 32'h8001_1234, 2'b10, 1'b1, 2'd1));
    send(1, ld_op(4'd6, 32'hA1B2_C3D4, 2'b11, 1'b1, 2'd3));
    send(1, ld_op(4'd7, 32'h7F80_01FF, 2'b01, 1'b1, 2'd0));
    @(negedge clk);
    chk("ld_cnt", if1.retired_cnt, exp_cnt1);

    // single port dual write: Rd then base, next offer held across the stall
    send(1, with_base(ld_op(4'd2, 32'hCAFE_F00D, 2'b00, 1'b0, 2'd0), 4'd5, 32'h100));
    chk("dual_ready_lo", {31'b0, if1.in_ready}, 32'd0);
    r = alu_op(4'd7, 32'h0BAD_CAFE);
    cur = r;
    push_exp(1, r);
    v1 = 1'b1;
    @(negedge clk);
    chk("wr2_ready_hi", {31'b0, if1.in_ready}, 32'd1);
    chk("wr2_num", {28'b0, if1.wb0_num}, 32'd5);
    chk("wr2_data", if1.wb0_data, 32'h100);
    @(posedge clk);
    @(negedge clk);
    v1 = 1'b0;
    chk("after_stall_num", {28'b0, if1.wb0_num}, 32'd7);
    @(negedge clk);
    chk("once_we", {31'b0, if1.wb0_we}, 32'd0);
    chk("dual_cnt", if1.retired_cnt, exp_cnt1);

    // Rd==base, base-only and no-enable entries on the single port instance
    send(1, with_base(ld_op(4'd4, 32'h1111_2222, 2'b00, 1'b0, 2'd0), 4'd4, 32'h200));
    chk("same_ready", {31'b0, if1.in_ready}, 32'd1);
    r = with_base(alu_op(4'd0, 32'h0), 4'd9, 32'h0000_0340);
    r.rd_we = 1'b0;
    send(1, r);
    r = alu_op(4'd8, 32'h5555_AAAA);
    r.rd_we = 1'b0;
    send(1, r);
    chk("none_we", {31'b0, if1.wb0_we}, 32'd0);
    @(negedge clk);
    chk("misc_cnt", if1.retired_cnt, exp_cnt1);

    // dual port instance: both writes in one cycle, no stall
    send(2, with_base(ld_op(4'd2, 32'hCAFE_F00D, 2'b00, 1'b0, 2'd0), 4'd5, 32'h100));
    chk("d2_ready", {31'b0, if2.in_ready}, 32'd1);
    chk("d2_wb1_we_dual", {31'b0, if2.wb1_we}, 32'd1);
    send(2, with_base(alu_op(4'd4, 32'h4444_0000), 4'd4, 32'h300));
    chk("d2_same_wb1", {31'b0, if2.wb1_we}, 32'd0);
    @(negedge clk);

    // flush of an offered entry
    cur = alu_op(4'd10, 32'hF1F1_F1F1);
    v1 = 1'b1;
    f1 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    v1 = 1'b0;
    f1 = 1'b0;
    chk("flush_we", {31'b0, if1.wb0_we}, 32'd0);
    @(negedge clk);
    chk("flush_cnt", if1.retired_cnt, exp_cnt1);

    // flush while a captured dual entry is in progress
    send(1, with_base(ld_op(4'd1, 32'h0000_00FF, 2'b01, 1'b0, 2'd0), 4'd6, 32'h600));
    f1 = 1'b1;
    @(negedge clk);
    chk("flush_wr2_we", {31'b0, if1.wb0_we}, 32'd1);
    chk("flush_wr2_num", {28'b0, if1.wb0_num}, 32'd6);
    f1 = 1'b0;
    @(negedge clk);
    chk("flush_wr2_cnt", if1.retired_cnt, exp_cnt1);

    // reset during the base write cycle
    send(1, with_base(alu_op(4'd3, 32'h3333_3333), 4'd11, 32'hB00));
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("rstwr2_we", {31'b0, if1.wb0_we}, 32'd0);
    chk("rstwr2_ready", {31'b0, if1.in_ready}, 32'd1);
    chk("rstwr2_cnt", if1.retired_cnt, 32'd0);
    if (q10.size() > 0) dropped = q10.pop_back();
    exp_cnt1 = 32'd0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // counter wrap
    #1;
    force dut1.cnt_q = 32'hFFFF_FFFE;
    #1;
    release dut1.cnt_q;
    exp_cnt1 = 32'hFFFF_FFFE;
    @(negedge clk);
    send(1, alu_op(4'd1, 32'h1));
    send(1, alu_op(4'd2, 32'h2));
    @(negedge clk);
    chk("wrap_cnt", if1.retired_cnt, 32'd0);
    chk("wrap_model", if1.retired_cnt, exp_cnt1);

    repeat (2) @(negedge clk);
    chk("q10_empty", q10.size(), 32'd0);
    chk("q20_empty", q20.size(), 32'd0);
    chk("q21_empty", q21.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
